// File: rtl/digit_display.sv
// rtl/digit_display.sv - 3-stage pipelined multi-digit glyph renderer with frame-synchronous digit snapshot
// Optional per-digit blinking is enabled by defining DIGIT_DISPLAY_BLINK_EN.
module digit_display #(
  parameter int                 NUM_DIGITS   = 4,
  parameter int                 DIGIT_W      = 3,
  parameter int                 GLYPH_W      = 21,
  parameter int                 GLYPH_H      = 23,
  parameter int                 GAP          = 2,
  parameter int                 ROM_BASE     = 23,
  parameter int                 COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] INK          = 3'b110,
  parameter logic [COLOR_W-1:0] BG           = 3'b000,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           frame_start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  digits,
  input  logic [NUM_DIGITS-1:0]          blink_mask,
  input  logic [9:0]                     x_px,
  input  logic [9:0]                     y_px,
  input  logic [9:0]                     x_scr,
  input  logic [9:0]                     y_scr,
  output logic [9:0]                     rom_x,
  output logic [9:0]                     rom_y,
  input  logic                           rom_pixel,
  output logic [COLOR_W-1:0]             color_px,
  output logic                           active
);

  localparam int PITCH   = GLYPH_W + GAP;
  localparam int FIELD_W = NUM_DIGITS * GLYPH_W + (NUM_DIGITS - 1) * GAP;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS*DIGIT_W-1:0] snap_q;
  logic [9:0]                    rom_x_q, rom_y_q;
  logic                          hit1_q, gap1_q, blank1_q;
  logic                          hit2_q, gap2_q, blank2_q;
  logic                          active_q;
  logic [COLOR_W-1:0]            color_q;

  logic [10:0]          x11, y11, xs11, ys11, dx;
  logic [9:0]           dy;
  logic                 in_field, in_cell;
  logic [IDX_W-1:0]     cell_k;
  logic [9:0]           cell_off;
  logic [DIGIT_W-1:0]   digit_val;
  logic                 blank_d;
  logic [9:0]           rom_x_d, rom_y_d;

  // 11-bit compares: a field hanging past 1023 clips instead of wrapping to x=0
  assign x11  = {1'b0, x_px};
  assign y11  = {1'b0, y_px};
  assign xs11 = {1'b0, x_scr};
  assign ys11 = {1'b0, y_scr};
  assign dx   = x11 - xs11;
  assign dy   = y_px - y_scr;

  assign in_field = (x11 >= xs11) && (x11 < xs11 + 11'(FIELD_W)) &&
                    (y11 >= ys11) && (y11 < ys11 + 11'(GLYPH_H));

  always_comb begin
    in_cell  = 1'b0;
    cell_k   = '0;
    cell_off = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dx >= 11'(i * PITCH) && dx < 11'(i * PITCH + GLYPH_W)) begin
        in_cell  = 1'b1;
        cell_k   = IDX_W'(i);
        cell_off = 10'(dx - 11'(i * PITCH));
      end
    end
  end

  assign digit_val = snap_q[int'(cell_k)*DIGIT_W +: DIGIT_W];
  assign rom_x_d   = (in_field && in_cell) ? cell_off : '0;
  assign rom_y_d   = (in_field && in_cell) ?
                     dy + 10'(int'(digit_val) * GLYPH_H) + 10'(ROM_BASE) : '0;

`ifdef DIGIT_DISPLAY_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             hidden_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        hidden_q    <= ~hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blank_d = hidden_q && blink_mask[cell_k];
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blank_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q   <= '0;
      rom_x_q  <= '0;
      rom_y_q  <= '0;
      hit1_q   <= 1'b0;
      gap1_q   <= 1'b0;
      blank1_q <= 1'b0;
      hit2_q   <= 1'b0;
      gap2_q   <= 1'b0;
      blank2_q <= 1'b0;
      active_q <= 1'b0;
      color_q  <= BG;
    end else begin
      if (frame_start) snap_q <= digits;
      rom_x_q  <= rom_x_d;
      rom_y_q  <= rom_y_d;
      hit1_q   <= in_field;
      gap1_q   <= in_field && !in_cell;
      blank1_q <= in_field && in_cell && blank_d;
      hit2_q   <= hit1_q;
      gap2_q   <= gap1_q;
      blank2_q <= blank1_q;
      active_q <= hit2_q;
      color_q  <= (hit2_q && !gap2_q && !blank2_q && rom_pixel) ? INK : BG;
    end
  end

  assign rom_x    = rom_x_q;
  assign rom_y    = rom_y_q;
  assign active   = active_q;
  assign color_px = color_q;

endmodule

// File: tb/tb_digit_display.sv
// tb/tb_digit_display.sv - randomized + directed bench for digit_display against a pixel-level reference model
// Define DIGIT_DISPLAY_BLINK_EN to exercise the blink build (BLINK_FRAMES=2).
module tb_digit_display;
  localparam int N = 4, DW = 3, GW = 21, GH = 23, GAP = 2, RB = 23;
  localparam logic [2:0] INK = 3'b110, BG = 3'b000;
  localparam int FW = N * GW + (N - 1) * GAP;
`ifdef DIGIT_DISPLAY_BLINK_EN
  localparam int BF = 2;
`else
  localparam int BF = 30;
`endif

  logic        clk = 1'b0, rstn = 1'b0, frame_start = 1'b0, rom_pixel = 1'b0;
  logic [11:0] digits = '0;
  logic [3:0]  blink_mask = '0;
  logic [9:0]  x_px = '0, y_px = '0, x_scr = '0, y_scr = '0;
  logic [9:0]  rom_x, rom_y;
  logic [2:0]  color_px;
  logic        active;

  int n_cmp = 0, n_bad = 0;
  bit force_one = 1'b0;

  typedef struct {int rx; int ry; bit act; logic [2:0] col;} exp_t;
  exp_t pq[$];
  int   m_snap = 0, m_frames = 0;

  digit_display #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .digits(digits),
    .blink_mask(blink_mask), .x_px(x_px), .y_px(y_px), .x_scr(x_scr), .y_scr(y_scr),
    .rom_x(rom_x), .rom_y(rom_y), .rom_pixel(rom_pixel), .color_px(color_px), .active(active)
  );

  always #5 clk = ~clk;

  function automatic bit rom_fn(int x, int y);
    return force_one || (((x * 13 + y * 7) % 5) < 2);
  endfunction

  // Synchronous glyph ROM: data one clock after the address
  always @(posedge clk) rom_pixel <= rom_fn(int'(rom_x), int'(rom_y));

  function automatic exp_t model(int x, int y);
    exp_t e;
    int dx, dy, k, off, val;
    bit inf, gapf, blank;
    dx = x - int'(x_scr);
    dy = y - int'(y_scr);
    inf = (dx >= 0) && (dx < FW) && (dy >= 0) && (dy < GH);
    e.act = inf; e.rx = 0; e.ry = 0; e.col = BG;
    if (inf) begin
      k = dx / (GW + GAP);
      off = dx % (GW + GAP);
      gapf = (off >= GW);
      val = (m_snap >> (k * DW)) & 7;
      blank = 1'b0;
`ifdef DIGIT_DISPLAY_BLINK_EN
      blank = (((m_frames / BF) % 2) == 1) && blink_mask[k];
`endif
      if (!gapf) begin
        e.rx = off;
        e.ry = (dy + val * GH + RB) % 1024;
        if (!blank && rom_fn(e.rx, e.ry)) e.col = INK;
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_t r;
    r.rx = 0; r.ry = 0; r.act = 1'b0; r.col = BG;
    m_snap = 0; m_frames = 0;
    pq.delete();
    repeat (3) pq.push_front(r);
  endtask

  task automatic cyc(input int x, input int y, input bit fs);
    exp_t e;
    @(negedge clk);
    rstn = 1'b1;
    x_px = 10'(x); y_px = 10'(y); frame_start = fs;
    e = model(x, y);
    pq.push_front(e);
    if (pq.size() > 3) void'(pq.pop_back());
    @(posedge clk);
    if (fs) begin m_snap = int'(digits); m_frames++; end
    #1;
    chk("rom_x", 32'(rom_x), 32'(pq[0].rx));
    chk("rom_y", 32'(rom_y), 32'(pq[0].ry));
    chk("active", 32'(active), 32'(pq[2].act));
    chk("color_px", 32'(color_px), 32'(pq[2].col));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_color"}, 32'(color_px), 32'(BG));
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_rom_x"}, 32'(rom_x), 32'd0);
    chk({tag, "_rom_y"}, 32'(rom_y), 32'd0);
  endtask

  // Pixels far outside any field, so in-flight ROM reads never matter
  task automatic flush();
    repeat (3) cyc(int'(x_scr) + FW + 40 < 1024 ? int'(x_scr) + FW + 40 : 0, int'(y_scr) + GH + 5, 1'b0);
  endtask

  // Reset pulse between clock edges; released at the next cyc() call
  task automatic mid_reset();
    #2 rstn = 1'b0;
    #1 check_reset_state("async_rst");
    model_reset();
    @(posedge clk); #1;
    check_reset_state("held_rst");
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_state("por");

    x_scr = 10'd100; y_scr = 10'd50; digits = 12'h0A3; blink_mask = 4'b0000;
    cyc(0, 0, 1'b1);
    cyc(100, 50, 1'b0);
    chk("first_rom_y_92", 32'(rom_y), 32'd92);
    cyc(110, 60, 1'b0);
    cyc(130, 50, 1'b0);
    chk("first_active", 32'(active), 32'd1);

    flush();
    force_one = 1'b1;
    cyc(121, 50, 1'b0);
    cyc(122, 50, 1'b0);
    cyc(123, 52, 1'b0);
    cyc(100 + FW - 1, 72, 1'b0);
    chk("gap_color", 32'(color_px), 32'(BG));
    chk("gap_active", 32'(active), 32'd1);
    cyc(100 + FW, 72, 1'b0);
    cyc(100, 73, 1'b0);
    flush();
    force_one = 1'b0;

    digits = 12'h5D7;
    cyc(100, 55, 1'b0);
    cyc(124, 55, 1'b0);
    cyc(0, 0, 1'b1);
    cyc(100, 55, 1'b0);
    cyc(124, 55, 1'b0);

    x_scr = 10'd1020; y_scr = 10'd10;
    cyc(3, 10, 1'b0);
    cyc(1020, 10, 1'b0);
    cyc(1023, 32, 1'b0);
    cyc(0, 10, 1'b0);
    cyc(1, 20, 1'b0);
    y_scr = 10'd1015;
    cyc(1021, 1020, 1'b0);
    cyc(1021, 2, 1'b0);
    cyc(0, 0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        x_scr = 10'($urandom_range(0, 1023));
        y_scr = 10'($urandom_range(0, 1023));
      end
      digits = 12'($urandom);
      blink_mask = 4'($urandom);
      cyc((int'(x_scr) + int'($urandom_range(0, FW + 10)) - 5 + 1024) % 1024,
          (int'(y_scr) + int'($urandom_range(0, GH + 4)) - 2 + 1024) % 1024,
          $urandom_range(0, 19) == 0);
    end

    x_scr = 10'd100; y_scr = 10'd50; digits = 12'h321; blink_mask = 4'b0001;
    flush();
    force_one = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cyc(0, 0, 1'b1);
      cyc(105, 51, 1'b0);
      cyc(130, 51, 1'b0);
      cyc(180, 60, 1'b0);
      cyc(0, 0, 1'b0);
      cyc(0, 0, 1'b0);
    end
    flush();
    force_one = 1'b0;

    cyc(101, 52, 1'b0);
    cyc(125, 53, 1'b0);
    mid_reset();
    digits = 12'h0A3;
    cyc(102, 52, 1'b1);
    cyc(103, 53, 1'b0);
    cyc(126, 54, 1'b0);
    cyc(150, 55, 1'b0);
    cyc(160, 60, 1'b0);
    cyc(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
